// File: rtl/conv_rd_addr_gen.sv
// conv_rd_addr_gen: walks the filter and IF scratchpads window by window,
// issuing one filter/IF read-address pair per cycle to the MAC datapath and
// reporting window, stride and row completion back to the PE controller.
module conv_rd_addr_gen #(
  parameter int FILT_ADDR_LEN = 4,
  parameter int IF_ADDR_LEN   = 5,
  parameter int STRIDE_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     start,
  input  logic [FILT_ADDR_LEN-1:0] filt_len,
  input  logic [IF_ADDR_LEN-1:0]   if_len,
  input  logic [STRIDE_W-1:0]      stride,
  input  logic                     stall,
  output logic [FILT_ADDR_LEN-1:0] filt_addr,
  output logic [IF_ADDR_LEN-1:0]   if_addr,
  output logic                     rd_valid,
  output logic                     psum_done,
  output logic                     stride_count_flag,
  output logic                     full_done,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, RUN, STRIDE, DONE} state_t;

  // Comparison width: two bits above the widest field so base + strd + flen
  // can never wrap, whichever parameter happens to be the widest.
  localparam int MAX_W = (FILT_ADDR_LEN > IF_ADDR_LEN) ?
                         ((FILT_ADDR_LEN > STRIDE_W) ? FILT_ADDR_LEN : STRIDE_W) :
                         ((IF_ADDR_LEN > STRIDE_W) ? IF_ADDR_LEN : STRIDE_W);
  localparam int CMP_W = MAX_W + 2;

  state_t state, state_nxt;

  logic [FILT_ADDR_LEN-1:0] flen;
  logic [FILT_ADDR_LEN-1:0] k;
  logic [IF_ADDR_LEN-1:0]   ilen;
  logic [IF_ADDR_LEN-1:0]   base;
  logic [STRIDE_W-1:0]      strd;

  logic [CMP_W-1:0] next_window_end;
  logic             last_tap;
  logic             end_row;
  logic             degenerate;

  // The next window would end at base + strd + flen; if that passes the
  // valid IF length the current window is the last one in the row.
  assign next_window_end = CMP_W'(base) + CMP_W'(strd) + CMP_W'(flen);
  assign end_row         = next_window_end > CMP_W'(ilen);
  // flen is never 0 while in RUN, so flen - 1 cannot underflow there.
  assign last_tap        = (k >= flen - FILT_ADDR_LEN'(1));
  // A row with no taps, or a filter longer than the IF row, has no windows.
  assign degenerate      = (filt_len == '0) || (CMP_W'(filt_len) > CMP_W'(if_len));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and output decode from the state and window registers.
  always_comb begin
    state_nxt         = state;
    rd_valid          = 1'b0;
    filt_addr         = '0;
    if_addr           = '0;
    psum_done         = 1'b0;
    stride_count_flag = 1'b0;
    full_done         = 1'b0;
    busy              = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = degenerate ? DONE : RUN;
      end
      RUN: begin
        rd_valid  = 1'b1;
        filt_addr = k;
        if_addr   = base + IF_ADDR_LEN'(k);
        if (!stall && last_tap) begin
          psum_done = 1'b1;
          state_nxt = end_row ? DONE : STRIDE;
        end
      end
      STRIDE: begin
        stride_count_flag = 1'b1;
        state_nxt         = RUN;
      end
      DONE: begin
        full_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Row parameters, window base and tap counter; parameters only load from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flen <= '0;
      ilen <= '0;
      strd <= '0;
      base <= '0;
      k    <= '0;
    end else if (clear) begin
      base <= '0;
      k    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            flen <= filt_len;
            ilen <= if_len;
            strd <= (stride == '0) ? STRIDE_W'(1) : stride;
            base <= '0;
            k    <= '0;
          end
        end
        RUN: begin
          if (!stall && !last_tap) k <= k + FILT_ADDR_LEN'(1);
        end
        STRIDE: begin
          base <= base + IF_ADDR_LEN'(strd);
          k    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
